// File: rtl/cpu_pkg.sv
// Shared types and encodings for the CPU controller: FSM states, opcode
// constants, ALU operation and register-write mux encodings.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_e;

  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  // op sub-field values for the MOV opcode
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

endpackage

// File: rtl/instr_dec.sv
// Combinational field extraction and sign-extension of the instruction register.
module instr_dec #(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       ir,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [2:0]        rn,
  output logic [2:0]        rd,
  output logic [1:0]        sh,
  output logic [2:0]        rm,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
  assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle controller: latches one instruction per start pulse and sequences
// the datapath strobes for MOV/ALU instructions. Outputs depend on state and IR only.
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic [15:0]       in,
  output logic              w,
  output logic              illegal,
  output logic [1:0]        vsel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              write,
  output logic              asel,
  output logic              bsel,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;

  instr_dec #(.DATA_W(DATA_W)) u_dec (
    .ir     (ir_q),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm5 (sximm5),
    .sximm8 (sximm8)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    w        = 1'b0;
    illegal  = 1'b0;
    vsel     = VSEL_C;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    shift    = 2'b00;
    ALUop    = ALU_ADD;

    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (s) begin
          ir_d    = in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == OP_MOV && op == MOV_IMM) begin
          state_d = S_WRITE_IMM;
        end else if (opcode == OP_MOV && op == MOV_REG) begin
          state_d = S_GET_B;
        end else if (opcode == OP_ALU) begin
          // MVN only needs the B operand
          state_d = (op == ALU_NOTB) ? S_GET_B : S_GET_A;
        end else begin
          illegal = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WRITE_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM8;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = S_ALU;
      end
      S_ALU: begin
        shift = sh;
        // MOV reg passes the shifted B through as 0 + B
        if (opcode == OP_MOV) begin
          asel  = 1'b1;
          ALUop = ALU_ADD;
        end else begin
          ALUop = op;
        end
        if (opcode == OP_ALU && op == ALU_SUB) begin
          loads   = 1'b1;
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: directed instructions push per-cycle expected
// control vectors into a queue that a negedge monitor pops and compares.
module tb_cpu_control_fsm;

  localparam int VW = 53;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [15:0] in;
  logic        w, illegal, loada, loadb, loadc, loads, write, asel, bsel;
  logic [1:0]  vsel, shift, ALUop;
  logic [2:0]  readnum, writenum;
  logic [15:0] sximm5, sximm8;

  logic [VW-1:0] exp_q[$];
  string         name_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  cpu_control_fsm #(.DATA_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .in       (in),
    .w        (w),
    .illegal  (illegal),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .write    (write),
    .asel     (asel),
    .bsel     (bsel),
    .readnum  (readnum),
    .writenum (writenum),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm5   (sximm5),
    .sximm8   (sximm8)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [VW-1:0] act_vec;
  assign act_vec = {w, illegal, vsel, loada, loadb, loadc, loads, write, asel, bsel,
                    readnum, writenum, shift, ALUop, sximm5, sximm8};

  function automatic logic [20:0] mk(input logic wv, input logic ill, input logic [1:0] vs,
                                     input logic la, input logic lb, input logic lc,
                                     input logic ls, input logic wr, input logic as,
                                     input logic [2:0] rn, input logic [2:0] wn,
                                     input logic [1:0] sh, input logic [1:0] aop);
    return {wv, ill, vs, la, lb, lc, ls, wr, as, 1'b0, rn, wn, sh, aop};
  endfunction

  task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [20:0] ctrl,
                      input logic [15:0] sx5, input logic [15:0] sx8);
    exp_q.push_back({ctrl, sx5, sx8});
    name_q.push_back(nm);
  endtask

  task automatic push_idle(input string nm, input logic [15:0] sx5, input logic [15:0] sx8);
    push(nm, mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00), sx5, sx8);
  endtask

  task automatic push_dec(input string nm, input logic ill,
                          input logic [15:0] sx5, input logic [15:0] sx8);
    push(nm, mk(0, ill, 2'b00, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00), sx5, sx8);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check(name_q.pop_front(), act_vec, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic start(input logic [15:0] instr);
    @(negedge clk);
    #1;
    in = instr;
    s  = 1'b1;
  endtask

  task automatic release_s();
    @(posedge clk);
    #1;
    s  = 1'b0;
    in = 16'($urandom_range(0, 16'hFFFF));
    wait_drain();
  endtask

  initial begin
    reset = 1'b1;
    s     = 1'b1;
    in    = 16'hD3FB;
    // reset held with s high: reset wins, IR stays 0
    push_idle("reset_s_high0", 16'h0000, 16'h0000);
    push_idle("reset_s_high1", 16'h0000, 16'h0000);
    wait_drain();
    reset = 1'b0;
    s     = 1'b0;

    // MOV R3,#-5
    start(16'hD3FB);
    push_dec("movi_dec", 0, 16'hFFFB, 16'hFFFB);
    push("movi_wimm", mk(0, 0, 2'b10, 0, 0, 0, 0, 1, 0, 3'd0, 3'd3, 2'b00, 2'b00), 16'hFFFB, 16'hFFFB);
    push_idle("movi_wait", 16'hFFFB, 16'hFFFB);
    release_s();

    // ADD R2,R1,R0 LSL#1
    start(16'hA148);
    push_dec("add_dec", 0, 16'h0008, 16'h0048);
    push("add_geta", mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 3'd1, 3'd0, 2'b00, 2'b00), 16'h0008, 16'h0048);
    push("add_getb", mk(0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00), 16'h0008, 16'h0048);
    push("add_alu",  mk(0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 3'd0, 3'd0, 2'b01, 2'b00), 16'h0008, 16'h0048);
    push("add_wreg", mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 3'd0, 3'd2, 2'b00, 2'b00), 16'h0008, 16'h0048);
    push_idle("add_wait", 16'h0008, 16'h0048);
    release_s();

    // CMP R1,R0
    start(16'hA900);
    push_dec("cmp_dec", 0, 16'h0000, 16'h0000);
    push("cmp_geta", mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 3'd1, 3'd0, 2'b00, 2'b00), 16'h0000, 16'h0000);
    push("cmp_getb", mk(0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00), 16'h0000, 16'h0000);
    push("cmp_alu",  mk(0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 3'd0, 3'd0, 2'b00, 2'b01), 16'h0000, 16'h0000);
    push_idle("cmp_wait", 16'h0000, 16'h0000);
    release_s();

    // MVN R4,R7 with s held high until WAIT is reached
    start(16'hB887);
    push_dec("mvn_dec", 0, 16'h0007, 16'hFF87);
    push("mvn_getb", mk(0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 3'd7, 3'd0, 2'b00, 2'b00), 16'h0007, 16'hFF87);
    push("mvn_alu",  mk(0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b11), 16'h0007, 16'hFF87);
    push("mvn_wreg", mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 3'd0, 3'd4, 2'b00, 2'b00), 16'h0007, 16'hFF87);
    push_idle("mvn_wait", 16'h0007, 16'hFF87);
    wait_drain();
    s = 1'b0;
    push_idle("mvn_idle", 16'h0007, 16'hFF87);
    wait_drain();

    // MOV R5,R2 ASR-style shift 10
    start(16'hC0B2);
    push_dec("movr_dec", 0, 16'hFFF2, 16'hFFB2);
    push("movr_getb", mk(0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 3'd2, 3'd0, 2'b00, 2'b00), 16'hFFF2, 16'hFFB2);
    push("movr_alu",  mk(0, 0, 2'b00, 0, 0, 1, 0, 0, 1, 3'd0, 3'd0, 2'b10, 2'b00), 16'hFFF2, 16'hFFB2);
    push("movr_wreg", mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 3'd0, 3'd5, 2'b00, 2'b00), 16'hFFF2, 16'hFFB2);
    push_idle("movr_wait", 16'hFFF2, 16'hFFB2);
    release_s();

    // AND R1,R3,R5
    start(16'hB325);
    push_dec("and_dec", 0, 16'h0005, 16'h0025);
    push("and_geta", mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 3'd3, 3'd0, 2'b00, 2'b00), 16'h0005, 16'h0025);
    push("and_getb", mk(0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 3'd5, 3'd0, 2'b00, 2'b00), 16'h0005, 16'h0025);
    push("and_alu",  mk(0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b10), 16'h0005, 16'h0025);
    push("and_wreg", mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 3'd0, 3'd1, 2'b00, 2'b00), 16'h0005, 16'h0025);
    push_idle("and_wait", 16'h0005, 16'h0025);
    release_s();

    // illegal opcode 111
    start(16'hE000);
    push_dec("ill_dec", 1, 16'h0000, 16'h0000);
    push_idle("ill_wait", 16'h0000, 16'h0000);
    push_idle("ill_idle", 16'h0000, 16'h0000);
    release_s();

    // illegal MOV sub-op 01
    start(16'hC800);
    push_dec("ill2_dec", 1, 16'h0000, 16'h0000);
    push_idle("ill2_wait", 16'h0000, 16'h0000);
    release_s();

    // reset asserted while an ADD sits in GET_B
    start(16'hA148);
    push_dec("rst_add_dec", 0, 16'h0008, 16'h0048);
    push("rst_add_geta", mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 3'd1, 3'd0, 2'b00, 2'b00), 16'h0008, 16'h0048);
    push("rst_add_getb", mk(0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00), 16'h0008, 16'h0048);
    release_s();
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_add", act_vec,
          {mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00), 16'h0000, 16'h0000});
    @(negedge clk);
    #1;
    reset = 1'b0;

    // first s after reset is accepted
    start(16'hD3FB);
    push_dec("post_rst_dec", 0, 16'hFFFB, 16'hFFFB);
    push("post_rst_wimm", mk(0, 0, 2'b10, 0, 0, 0, 0, 1, 0, 3'd0, 3'd3, 2'b00, 2'b00), 16'hFFFB, 16'hFFFB);
    push_idle("post_rst_wait", 16'hFFFB, 16'hFFFB);
    release_s();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
